// File: rtl/srt4_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : srt4_seq_ctrl                                        |
// | Description : Sequencer for a radix-4 SRT divider. Issues load and  |
// |               step strobes to the datapath, collects NDIG signed    |
// |               quotient digits and converts them to a binary         |
// |               mantissa through a positive/negative accumulator pair.|
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module srt4_seq_ctrl #(
   parameter int NDIG = 13
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic                abort,
   output logic                dp_load,
   output logic                dp_step,
   input  logic [2:0]          dp_digit,
   output logic [3*NDIG-1:0]   digits,
   output logic [2*NDIG-4:0]   mantissa,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                busy,
   output logic                digit_err
);

   localparam int W  = 2 * NDIG;
   localparam int CW = $clog2(NDIG) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ITER = 3'd2,
      S_CONV = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [W-1:0]        pos_q, neg_q;
   logic [3*NDIG-1:0]   digits_q;
   logic [W-4:0]        mant_q;
   logic [CW-1:0]       cnt_q;
   logic                err_q;

   logic [1:0]          w_p, w_n;
   logic                w_ill;
   logic                w_last;
   logic                w_borrow;
   logic [W-4:0]        w_mant;

   // Decode the datapath digit into positive/negative bit pairs.
   always_comb begin
      w_p   = 2'b00;
      w_n   = 2'b00;
      w_ill = 1'b0;
      case (dp_digit)
         3'b000:  ;
         3'b001:  w_p = 2'b01;
         3'b010:  w_p = 2'b10;
         3'b110:  w_n = 2'b01;
         3'b101:  w_n = 2'b10;
         default: w_ill = 1'b1;
      endcase
   end

   assign w_last = (cnt_q == CW'(NDIG - 1));

   // Upper bits of (pos - neg): subtract the kept fields and take the
   // borrow out of the three discarded low bits.
   assign w_borrow = (pos_q[2:0] < neg_q[2:0]);
   assign w_mant   = pos_q[W-1:3] - neg_q[W-1:3] - {{(W-4){1'b0}}, w_borrow};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state selection and Moore strobes.
   always_comb begin
      state_d     = state_q;
      start_ready = 1'b0;
      dp_load     = 1'b0;
      dp_step     = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) state_d = S_LOAD;
         end
         S_LOAD: begin
            dp_load = 1'b1;
            state_d = abort ? S_IDLE : S_ITER;
         end
         S_ITER: begin
            dp_step = 1'b1;
            if (abort)       state_d = S_IDLE;
            else if (w_last) state_d = S_CONV;
         end
         S_CONV: begin
            state_d = abort ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Accumulators, digit collection, counter and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q    <= '0;
         neg_q    <= '0;
         digits_q <= '0;
         mant_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_valid) begin
                  pos_q    <= '0;
                  neg_q    <= '0;
                  digits_q <= '0;
                  cnt_q    <= '0;
                  err_q    <= 1'b0;
               end
            end
            S_LOAD, S_CONV, S_ITER: begin
               if (abort) begin
                  pos_q    <= '0;
                  neg_q    <= '0;
                  digits_q <= '0;
                  mant_q   <= '0;
                  cnt_q    <= '0;
               end else if (state_q == S_ITER) begin
                  pos_q    <= {pos_q[W-3:0], w_p};
                  neg_q    <= {neg_q[W-3:0], w_n};
                  digits_q <= {digits_q[3*NDIG-4:0], dp_digit};
                  cnt_q    <= cnt_q + CW'(1);
                  err_q    <= err_q | w_ill;
               end else if (state_q == S_CONV) begin
                  mant_q   <= w_mant;
               end
            end
            default: ;
         endcase
      end
   end

   assign digits    = digits_q;
   assign mantissa  = mant_q;
   assign digit_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_srt4_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_srt4_seq_ctrl                                     |
// | Description : Scoreboard bench for srt4_seq_ctrl with directed      |
// |               digit vectors and hand-computed results.             |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module tb_srt4_seq_ctrl;

   localparam int NDIG = 13;
   localparam int DW   = 3 * NDIG;
   localparam int MW   = 2 * NDIG - 3;

   localparam logic [DW-1:0] V1 = 39'h1249249249;
   localparam logic [MW-1:0] M1 = 23'h2AAAAA;
   localparam logic [DW-1:0] V2 = 39'h2000000000;
   localparam logic [MW-1:0] M2 = 23'h400000;
   localparam logic [DW-1:0] V3 = 39'h1C00000000;
   localparam logic [MW-1:0] M3 = 23'h180000;
   localparam logic [DW-1:0] V4 = 39'h124F249249;
   localparam logic [MW-1:0] M4 = 23'h2A8AAA;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_valid;
   logic            start_ready;
   logic            abort;
   logic            dp_load;
   logic            dp_step;
   logic [2:0]      dp_digit;
   logic [DW-1:0]   digits;
   logic [MW-1:0]   mantissa;
   logic            res_valid;
   logic            res_ready;
   logic            busy;
   logic            digit_err;

   typedef struct {
      logic [DW-1:0] dig;
      logic [MW-1:0] mant;
      logic          err;
      int            acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   srt4_seq_ctrl #(.NDIG(NDIG)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .abort       (abort),
      .dp_load     (dp_load),
      .dp_step     (dp_step),
      .dp_digit    (dp_digit),
      .digits      (digits),
      .mantissa    (mantissa),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy),
      .digit_err   (digit_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: latency on the rising edge of res_valid, payload on handshake.
   initial begin
      logic prev_rv;
      prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         if (res_valid && !prev_rv) begin
            if (sb.size() == 0) chk("unexpected_res_valid", 64'(res_valid), 64'd0);
            else                chk("latency", 64'(cyc - sb[0].acc), 64'(NDIG + 2));
         end
         if (res_valid && res_ready && sb.size() > 0) begin
            chk("digits",    64'(digits),    64'(sb[0].dig));
            chk("mantissa",  64'(mantissa),  64'(sb[0].mant));
            chk("digit_err", 64'(digit_err), 64'(sb[0].err));
            void'(sb.pop_front());
         end
         prev_rv = res_valid;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Issue a start and wait for acceptance; optionally queue the expected result.
   task automatic start_div(input logic [DW-1:0] vec, input logic [MW-1:0] mant,
                            input logic err, input bit push);
      int   guard;
      exp_t e;
      start_valid = 1'b1;
      guard = 0;
      while (!start_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!start_ready) chk("start_wait_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      start_valid = 1'b0;
      if (push) begin
         e.dig  = vec;
         e.mant = mant;
         e.err  = err;
         e.acc  = cyc;
         sb.push_back(e);
      end
   endtask

   // Present digits of vec on each dp_step cycle, nsteps of them.
   task automatic feed(input logic [DW-1:0] vec, input int nsteps);
      int i;
      int guard;
      i = 0;
      guard = 0;
      while (i < nsteps && guard < 40) begin
         @(posedge clk); #1;
         guard++;
         if (dp_step) begin
            dp_digit = vec[DW-1-3*i -: 3];
            i++;
         end
      end
      if (i != nsteps) chk("feed_timeout", 64'(i), 64'(nsteps));
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (!start_ready && guard < 60) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!start_ready) chk("idle_timeout", 64'd0, 64'd1);
      dp_digit = 3'b000;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_dp_step"},     64'(dp_step),     64'd0);
      chk({tag, "_busy"},        64'(busy),        64'd0);
      chk({tag, "_start_ready"}, 64'(start_ready), 64'd1);
      chk({tag, "_res_valid"},   64'(res_valid),   64'd0);
      chk({tag, "_digits"},      64'(digits),      64'd0);
      chk({tag, "_mantissa"},    64'(mantissa),    64'd0);
   endtask

   initial begin
      int guard;
      rst         = 1'b1;
      start_valid = 1'b0;
      abort       = 1'b0;
      dp_digit    = 3'b000;
      res_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_busy",        64'(busy),        64'd0);
      chk("rst_dp_load",     64'(dp_load),     64'd0);
      chk("rst_dp_step",     64'(dp_step),     64'd0);
      chk("rst_res_valid",   64'(res_valid),   64'd0);
      chk("rst_digit_err",   64'(digit_err),   64'd0);
      chk("rst_digits",      64'(digits),      64'd0);
      chk("rst_mantissa",    64'(mantissa),    64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // All +1 digits.
      start_div(V1, M1, 1'b0, 1'b1);
      chk("load_pulse", 64'(dp_load), 64'd1);
      feed(V1, NDIG);
      wait_idle();

      // Single +2 leading digit.
      start_div(V2, M2, 1'b0, 1'b1);
      feed(V2, NDIG);
      wait_idle();

      // +1 then -1: borrow through the accumulators.
      start_div(V3, M3, 1'b0, 1'b1);
      feed(V3, NDIG);
      wait_idle();

      // Illegal fifth digit.
      start_div(V4, M4, 1'b1, 1'b1);
      feed(V4, NDIG);
      wait_idle();

      // Next start clears the sticky error while in LOAD.
      start_div(V1, M1, 1'b0, 1'b1);
      chk("err_clear_in_load", 64'({dp_load, digit_err}), 64'b10);
      feed(V1, NDIG);
      wait_idle();

      // Back-pressure in DONE with start_valid pulsing.
      res_ready = 1'b0;
      start_div(V2, M2, 1'b0, 1'b1);
      feed(V2, NDIG);
      guard = 0;
      while (!res_valid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("done_reached", 64'(res_valid), 64'd1);
      for (int k = 0; k < 10; k++) begin
         start_valid = k[0];
         @(posedge clk); #1;
         chk("hold_outputs", {1'b0, start_ready, res_valid, digits, mantissa},
             {1'b0, 1'b0, 1'b1, V2, M2});
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      @(posedge clk); #1;
      chk("release_idle", 64'({start_ready, res_valid, dp_load}), 64'b100);
      chk("retain_digits", 64'(digits), 64'(V2));
      @(posedge clk); #1;
      chk("no_stray_load", 64'(dp_load), 64'd0);

      // Reset at the sixth ITER cycle.
      start_div(V1, M1, 1'b0, 1'b0);
      feed(V1, 6);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_cleared("rst_mid");
      dp_digit = 3'b000;
      repeat (20) @(posedge clk);
      #1;

      // Make the mantissa nonzero, then abort at the sixth ITER cycle.
      start_div(V3, M3, 1'b0, 1'b1);
      feed(V3, NDIG);
      wait_idle();
      start_div(V1, M1, 1'b0, 1'b0);
      feed(V1, 6);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_cleared("abort_mid");
      dp_digit = 3'b000;
      repeat (20) @(posedge clk);
      #1;

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/srt4_seq_ctrl.md
SRT4_SEQ_CTRL -- requirements
Module: srt4_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: NDIG, default 13, number of radix-4 quotient digits per division.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start_valid  input  1  request to begin a division.
REQ-006 start_ready  output  1  high only in IDLE.
REQ-007 abort  input  1  cancel an in-flight division.
REQ-008 dp_load  output  1  one-cycle pulse telling the SRT datapath to load its operands.
REQ-009 dp_step  output  1  datapath advances one iteration in this cycle.
REQ-010 dp_digit  input  3  quotient digit from the datapath, sampled in the same cycle as dp_step.
REQ-011 digits  output  3*NDIG  collected raw digit codes, first digit in the most significant field.
REQ-012 mantissa  output  2*NDIG-3  binary quotient mantissa (23 bits at the default).
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 digit_err  output  1  sticky flag: an illegal digit code was seen in the current division.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, ITER, CONV and DONE.
REQ-018 IDLE: start_valid&&start_ready at edge T -> LOAD; LOAD clears pos/neg accumulators, digits, iteration counter and digit_err.
REQ-019 LOAD: dp_load=1 for exactly one cycle (T+1) -> ITER.
REQ-020 ITER: dp_step=1 every cycle, NDIG consecutive cycles (T+2..T+NDIG+1); the last step -> CONV.
REQ-021 Digit decode each step: 000 = 0, 001 = +1, 010 = +2, 110 = -1, 101 = -2.
REQ-022 Each step SHALL shift into the accumulators: pos = {pos[2*NDIG-3:0], p}, neg = {neg[2*NDIG-3:0], n}, where (p,n) = (00,00) for 0, (01,00) for +1, (10,00) for +2, (00,01) for -1, (00,10) for -2.
REQ-023 Each step SHALL also shift dp_digit into the low field of digits.
REQ-024 Illegal codes (011, 100, 111) SHALL decode as 0 and set digit_err, which holds until the next LOAD.
REQ-025 CONV: one cycle; the block registers diff = (pos - neg) mod 2^(2*NDIG) and sets mantissa = diff[2*NDIG-1:3] -> DONE.
REQ-026 Sign wrap in diff is not flagged.
REQ-027 DONE: res_valid=1 from cycle T+NDIG+3 (T+16 at default); held with digits, mantissa and digit_err stable until res_valid&&res_ready, then -> IDLE.
REQ-028 start_valid outside IDLE SHALL be ignored; start_ready=0 in DONE even when res_ready is high.
REQ-029 abort in LOAD, ITER or CONV: next state IDLE, dp_step=0 next cycle, no res_valid, digits/mantissa cleared to 0; abort in IDLE or DONE is ignored.
REQ-030 rst takes priority over abort and start_valid.
REQ-031 After the handshake, digits and mantissa SHALL retain their values in IDLE until the next LOAD.
REQ-032 The iteration counter SHALL be ceil(log2(NDIG))+1 bits wide and never wrap within a division.

Reset
REQ-033 rst in any state SHALL force IDLE on the next edge.
REQ-034 On reset: start_ready=1; dp_load, dp_step, res_valid, busy and digit_err = 0; digits, mantissa, pos, neg and counter = 0.
REQ-035 Reset mid-ITER SHALL discard partial results with no res_valid pulse.

Verification
REQ-036 13 digits of 001 -> digits=0x1249249249, pos=0x1555555, neg=0, mantissa=0x2AAAAA, res_valid at T+16, digit_err=0.
REQ-037 Digit1=010, rest 000 -> pos=0x2000000, mantissa=0x400000.
REQ-038 Digit1=001, digit2=110, rest 000 -> pos=0x1000000, neg=0x0400000, diff=0xC00000, mantissa=0x180000.
REQ-039 Digit5=111, others 001 -> digit5 treated as 0, digit_err=1 with res_valid; next start clears digit_err in LOAD.
REQ-040 res_ready low for 10 cycles in DONE, start_valid pulsed meanwhile -> outputs stable, start not accepted; res_ready=1 -> IDLE next cycle, start_ready=1.
REQ-041 rst, then separately abort, asserted at the 6th ITER cycle -> IDLE next cycle, dp_step=0, no res_valid, digits=0, mantissa=0.
